arbitro_partita: RTL and testbench

- Match sequencer for the rock-paper-scissors round core (`manche`).
- Collects one move from each of two players over independent valid/ready channels and aborts a round if the second move does not arrive in time.
- Issues each complete move pair to the core for exactly one cycle, with INIZIA on the first round of a match, then samples the round and match results.
- Reports each round and stops when the core signals match end or a round cap is reached.

---
 rtl/arbitro_pkg.sv | 28 ++
 rtl/slot_move.sv | 51 +++++
 rtl/arbitro_partita.sv | 202 ++++++++++++++++++++
 tb/tb_arbitro_partita.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// Shared encodings and FSM state type for the rock-paper-scissors match sequencer.
package arbitro_pkg;

  localparam logic [1:0] MoveNone    = 2'b00;
  localparam logic [1:0] MoveSasso   = 2'b01;
  localparam logic [1:0] MoveCarta   = 2'b10;
  localparam logic [1:0] MoveForbice = 2'b11;

  localparam logic [1:0] MancheNone = 2'b00;
  localparam logic [1:0] MancheP1   = 2'b01;
  localparam logic [1:0] MancheP2   = 2'b10;
  localparam logic [1:0] MancheDraw = 2'b11;

  localparam logic [1:0] PartitaRun  = 2'b00;
  localparam logic [1:0] PartitaP1   = 2'b01;
  localparam logic [1:0] PartitaP2   = 2'b10;
  localparam logic [1:0] PartitaDraw = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StIssue,
    StWaitRes,
    StReport,
    StDone
  } state_e;

endpackage

// File: rtl/slot_move.sv
// Single-player move capture slot: valid/ready intake, drops the 00 move, clearable.
module slot_move (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [1:0] move_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       full_o,
  output logic [1:0] move_o,
  output logic       take_o,
  output logic       reject_o
);
  import arbitro_pkg::*;

  logic       full_q, full_d;
  logic [1:0] move_q, move_d;
  logic       xfer;

  assign ready_o  = en_i & ~full_q;
  assign xfer     = valid_i & ready_o;
  assign take_o   = xfer & (move_i != MoveNone);
  assign reject_o = xfer & (move_i == MoveNone);

  always_comb begin
    full_d = full_q;
    move_d = move_q;
    if (clr_i) begin
      full_d = 1'b0;
      move_d = MoveNone;
    end else if (take_o) begin
      full_d = 1'b1;
      move_d = move_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      move_q <= MoveNone;
    end else begin
      full_q <= full_d;
      move_q <= move_d;
    end
  end

  assign full_o = full_q;
  assign move_o = move_q;

endmodule

// File: rtl/arbitro_partita.sv
// Match sequencer: collects both players' moves, drives the round core for one cycle,
// samples its verdict and tracks rounds until the match ends or the round cap is hit.
module arbitro_partita #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CORE_LAT    = 1,
  parameter int unsigned MAX_ROUNDS  = 15,
  parameter int unsigned RCNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        p1_move,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [1:0]        p2_move,
  input  logic              p2_valid,
  output logic              p2_ready,
  output logic [1:0]        core_primo,
  output logic [1:0]        core_secondo,
  output logic              core_inizia,
  input  logic [1:0]        core_manche,
  input  logic [1:0]        core_partita,
  output logic              res_valid,
  output logic [1:0]        res_manche,
  output logic [1:0]        res_partita,
  output logic [RCNT_W-1:0] round_cnt,
  output logic              busy,
  output logic              match_over,
  output logic              timeout_pulse,
  output logic              bad_move
);
  import arbitro_pkg::*;

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned LatW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  state_e            state_q, state_d;
  logic              first_q, first_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [RCNT_W-1:0] round_cnt_q, round_cnt_d;
  logic [1:0]        res_manche_q, res_manche_d;
  logic [1:0]        res_partita_q, res_partita_d;
  logic              res_valid_q, res_valid_d;
  logic              timeout_q, timeout_d;
  logic              bad_q, bad_d;
  logic [1:0]        primo_q, primo_d;
  logic [1:0]        secondo_q, secondo_d;
  logic              inizia_q, inizia_d;

  logic       collect, clr_slots;
  logic       p1_full, p1_take, p1_reject;
  logic       p2_full, p2_take, p2_reject;
  logic [1:0] p1_data, p2_data;

  assign collect = (state_q == StCollect);

  slot_move u_slot_p1 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (collect),
    .clr_i    (clr_slots),
    .move_i   (p1_move),
    .valid_i  (p1_valid),
    .ready_o  (p1_ready),
    .full_o   (p1_full),
    .move_o   (p1_data),
    .take_o   (p1_take),
    .reject_o (p1_reject)
  );

  slot_move u_slot_p2 (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (collect),
    .clr_i    (clr_slots),
    .move_i   (p2_move),
    .valid_i  (p2_valid),
    .ready_o  (p2_ready),
    .full_o   (p2_full),
    .move_o   (p2_data),
    .take_o   (p2_take),
    .reject_o (p2_reject)
  );

  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    tmo_cnt_d     = '0;
    lat_cnt_d     = '0;
    round_cnt_d   = round_cnt_q;
    res_manche_d  = res_manche_q;
    res_partita_d = res_partita_q;
    res_valid_d   = 1'b0;
    timeout_d     = 1'b0;
    bad_d         = p1_reject | p2_reject;
    primo_d       = MoveNone;
    secondo_d     = MoveNone;
    inizia_d      = 1'b0;
    clr_slots     = 1'b0;

    if (start) begin
      // A start pulse always (re)opens a fresh match, dropping anything in flight.
      state_d       = StCollect;
      first_d       = 1'b1;
      round_cnt_d   = '0;
      res_manche_d  = MancheNone;
      res_partita_d = PartitaRun;
      clr_slots     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
        end
        StCollect: begin
          if ((p1_full | p1_take) && (p2_full | p2_take)) begin
            // Moves captured on this same edge come straight from the inputs.
            state_d   = StIssue;
            primo_d   = p1_full ? p1_data : p1_move;
            secondo_d = p2_full ? p2_data : p2_move;
            inizia_d  = first_q;
          end else if (p1_full ^ p2_full) begin
            if (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1)) begin
              clr_slots = 1'b1;
              timeout_d = 1'b1;
            end else begin
              tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
          end
        end
        StIssue: begin
          state_d   = StWaitRes;
          first_d   = 1'b0;
          clr_slots = 1'b1;
        end
        StWaitRes: begin
          if (lat_cnt_q == LatW'(CORE_LAT - 1)) begin
            state_d       = StReport;
            res_manche_d  = core_manche;
            res_partita_d = core_partita;
          end else begin
            lat_cnt_d = lat_cnt_q + 1'b1;
          end
        end
        StReport: begin
          res_valid_d = 1'b1;
          round_cnt_d = round_cnt_q + 1'b1;
          if (res_partita_q != PartitaRun || round_cnt_d == RCNT_W'(MAX_ROUNDS)) begin
            state_d = StDone;
          end else begin
            state_d = StCollect;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      first_q       <= 1'b0;
      tmo_cnt_q     <= '0;
      lat_cnt_q     <= '0;
      round_cnt_q   <= '0;
      res_manche_q  <= MancheNone;
      res_partita_q <= PartitaRun;
      res_valid_q   <= 1'b0;
      timeout_q     <= 1'b0;
      bad_q         <= 1'b0;
      primo_q       <= MoveNone;
      secondo_q     <= MoveNone;
      inizia_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      tmo_cnt_q     <= tmo_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      round_cnt_q   <= round_cnt_d;
      res_manche_q  <= res_manche_d;
      res_partita_q <= res_partita_d;
      res_valid_q   <= res_valid_d;
      timeout_q     <= timeout_d;
      bad_q         <= bad_d;
      primo_q       <= primo_d;
      secondo_q     <= secondo_d;
      inizia_q      <= inizia_d;
    end
  end

  assign core_primo    = primo_q;
  assign core_secondo  = secondo_q;
  assign core_inizia   = inizia_q;
  assign res_valid     = res_valid_q;
  assign res_manche    = res_manche_q;
  assign res_partita   = res_partita_q;
  assign round_cnt     = round_cnt_q;
  assign busy          = (state_q != StIdle) && (state_q != StDone);
  assign match_over    = (state_q == StDone);
  assign timeout_pulse = timeout_q;
  assign bad_move      = bad_q;

endmodule

// File: tb/tb_arbitro_partita.sv
// Randomized bench for arbitro_partita with a round-core stub and a round-level model.
module tb_arbitro_partita;

  localparam int unsigned TimeoutCyc = 16;
  localparam int unsigned CoreLat    = 1;
  localparam int unsigned MaxRounds  = 3;
  localparam int unsigned RcntW      = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       p1_move = 2'b00;
  logic             p1_valid = 1'b0;
  logic             p1_ready;
  logic [1:0]       p2_move = 2'b00;
  logic             p2_valid = 1'b0;
  logic             p2_ready;
  logic [1:0]       core_primo, core_secondo;
  logic             core_inizia;
  logic [1:0]       core_manche, core_partita;
  logic             res_valid;
  logic [1:0]       res_manche, res_partita;
  logic [RcntW-1:0] round_cnt;
  logic             busy, match_over, timeout_pulse, bad_move;

  int n_checks = 0;
  int n_fail   = 0;

  // Round-level model of the match.
  int m_rounds;
  bit m_done;
  bit m_first;

  logic [1:0] stub_partita = 2'b00;

  always #5 clk = ~clk;

  arbitro_partita #(
    .TIMEOUT_CYC (TimeoutCyc),
    .CORE_LAT    (CoreLat),
    .MAX_ROUNDS  (MaxRounds),
    .RCNT_W      (RcntW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .p1_move       (p1_move),
    .p1_valid      (p1_valid),
    .p1_ready      (p1_ready),
    .p2_move       (p2_move),
    .p2_valid      (p2_valid),
    .p2_ready      (p2_ready),
    .core_primo    (core_primo),
    .core_secondo  (core_secondo),
    .core_inizia   (core_inizia),
    .core_manche   (core_manche),
    .core_partita  (core_partita),
    .res_valid     (res_valid),
    .res_manche    (res_manche),
    .res_partita   (res_partita),
    .round_cnt     (round_cnt),
    .busy          (busy),
    .match_over    (match_over),
    .timeout_pulse (timeout_pulse),
    .bad_move      (bad_move)
  );

  // Rock-paper-scissors verdict by modular difference of the move codes.
  function automatic logic [1:0] rps(input logic [1:0] a, input logic [1:0] b);
    int d;
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    d = (int'(a) - int'(b) + 3) % 3;
    if (d == 0) return 2'b11;
    return (d == 1) ? 2'b01 : 2'b10;
  endfunction

  // Core stub: result appears CoreLat edges after the issue cycle, for one cycle only.
  logic       pipe_v [CoreLat];
  logic [1:0] pipe_m [CoreLat];
  logic [1:0] pipe_p [CoreLat];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CoreLat; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_m[i] <= 2'b00;
        pipe_p[i] <= 2'b00;
      end
    end else begin
      pipe_v[0] <= (core_primo != 2'b00);
      pipe_m[0] <= rps(core_primo, core_secondo);
      pipe_p[0] <= stub_partita;
      for (int i = 1; i < CoreLat; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_m[i] <= pipe_m[i-1];
        pipe_p[i] <= pipe_p[i-1];
      end
    end
  end

  assign core_manche  = pipe_v[CoreLat-1] ? pipe_m[CoreLat-1] : 2'b00;
  assign core_partita = pipe_v[CoreLat-1] ? pipe_p[CoreLat-1] : 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_rounds = 0;
    m_done   = 1'b0;
    m_first  = 1'b1;
    check_eq("start_busy", busy, 1);
    check_eq("start_cnt", round_cnt, 0);
    check_eq("start_res", {res_manche, res_partita}, 0);
    check_eq("start_ready", {p1_ready, p2_ready}, 2'b11);
  endtask

  // One complete round: transfers land on edges d1/d2; optional 00 from p1 on edge bad_at.
  task automatic run_round(input logic [1:0] m1, input int d1, input logic [1:0] m2,
                           input int d2, input logic [1:0] part, input int bad_at);
    int last;
    int bad_seen;
    last     = (d1 > d2) ? d1 : d2;
    bad_seen = 0;
    stub_partita = part;
    for (int cyc = 0; cyc <= last; cyc++) begin
      p1_valid = (cyc == d1) || (cyc == bad_at);
      p1_move  = (cyc == bad_at) ? 2'b00 : m1;
      p2_valid = (cyc == d2);
      p2_move  = m2;
      tick();
      bad_seen += int'(bad_move);
      check_eq("collect_res_valid", res_valid, 0);
      check_eq("collect_timeout", timeout_pulse, 0);
      if (cyc < last) begin
        check_eq("p1_ready", p1_ready, cyc < d1);
        check_eq("p2_ready", p2_ready, cyc < d2);
      end
    end
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    p1_move  = 2'b00;
    p2_move  = 2'b00;
    check_eq("bad_move_count", bad_seen, bad_at >= 0);
    check_eq("issue_primo", core_primo, m1);
    check_eq("issue_secondo", core_secondo, m2);
    check_eq("issue_inizia", core_inizia, m_first);
    check_eq("issue_ready", {p1_ready, p2_ready}, 0);
    m_first = 1'b0;
    for (int k = 1; k <= CoreLat + 1; k++) begin
      tick();
      check_eq("early_res_valid", res_valid, 0);
      check_eq("core_idle", {core_primo, core_secondo, core_inizia}, 0);
    end
    tick();
    m_rounds++;
    m_done = (part != 2'b00) || (m_rounds == MaxRounds);
    check_eq("res_valid", res_valid, 1);
    check_eq("res_manche", res_manche, rps(m1, m2));
    check_eq("res_partita", res_partita, part);
    check_eq("round_cnt", round_cnt, m_rounds);
    check_eq("match_over", match_over, m_done);
    check_eq("busy", busy, !m_done);
    tick();
    check_eq("res_valid_once", res_valid, 0);
    check_eq("ready_after", p1_ready, !m_done);
  endtask

  // A lone move from player pl on edge d; the round must abort TimeoutCyc edges later.
  task automatic run_timeout(input int pl, input logic [1:0] m, input int d);
    for (int cyc = 0; cyc <= d + int'(TimeoutCyc); cyc++) begin
      p1_valid = (pl == 1) && (cyc == d);
      p2_valid = (pl == 2) && (cyc == d);
      p1_move  = m;
      p2_move  = m;
      tick();
      check_eq("tmo_pulse", timeout_pulse, cyc == d + int'(TimeoutCyc));
      check_eq("tmo_own_ready", (pl == 1) ? p1_ready : p2_ready,
               !(cyc >= d && cyc < d + int'(TimeoutCyc)));
      check_eq("tmo_other_ready", (pl == 1) ? p2_ready : p1_ready, 1);
      check_eq("tmo_no_issue", {core_primo, core_secondo, core_inizia}, 0);
    end
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    p1_move  = 2'b00;
    p2_move  = 2'b00;
    check_eq("tmo_round_cnt", round_cnt, m_rounds);
    check_eq("tmo_busy", busy, 1);
    tick();
    check_eq("tmo_pulse_once", timeout_pulse, 0);
  endtask

  initial begin
    logic [19:0] all_out;
    int          d1, d2, bad_at;
    logic [1:0]  m1, m2, part;

    #1;
    all_out = {p1_ready, p2_ready, core_primo, core_secondo, core_inizia, res_valid, res_manche,
               res_partita, round_cnt, busy, match_over, timeout_pulse, bad_move};
    check_eq("reset_outputs", all_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy", {busy, match_over, p1_ready, p2_ready}, 0);

    // Two directed rounds ending on PARTITA=01.
    do_start();
    run_round(2'b10, 0, 2'b01, 0, 2'b00, -1);
    run_round(2'b11, 0, 2'b11, 0, 2'b01, -1);
    p1_valid = 1'b1;
    p1_move  = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("done_ready", {p1_ready, p2_ready}, 0);
      check_eq("done_hold", {match_over, busy}, 2'b10);
      check_eq("done_no_bad", bad_move, 0);
    end
    p1_valid = 1'b0;

    // Timeout, then a rejected 00 move followed by a real one, second move on the boundary.
    do_start();
    run_timeout(1, 2'b01, 0);
    run_round(2'b01, 3, 2'b10, 1, 2'b00, 0);
    run_round(2'b10, 0, 2'b11, int'(TimeoutCyc), 2'b00, -1);

    // Round cap.
    do_start();
    for (int r = 0; r < int'(MaxRounds); r++) run_round(2'b01, r, 2'b11, 0, 2'b00, -1);
    check_eq("cap_done", match_over, 1);
    check_eq("cap_cnt", round_cnt, MaxRounds);

    // Abort during WAIT_RES.
    do_start();
    stub_partita = 2'b00;
    p1_valid = 1'b1;
    p1_move  = 2'b01;
    p2_valid = 1'b1;
    p2_move  = 2'b10;
    tick();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("abort_no_res", res_valid, 0);
      check_eq("abort_cnt", round_cnt, 0);
      check_eq("abort_core", {core_primo, core_secondo, core_inizia}, 0);
      check_eq("abort_busy", busy, 1);
      tick();
    end
    m_rounds = 0;
    m_first  = 1'b1;
    m_done   = 1'b0;
    run_round(2'b11, 1, 2'b01, 2, 2'b00, -1);

    // Randomized matches.
    for (int mt = 0; mt < 6; mt++) begin
      do_start();
      while (!m_done) begin
        if ($urandom_range(0, 4) == 0) begin
          run_timeout(int'($urandom_range(1, 2)), 2'($urandom_range(1, 3)),
                      int'($urandom_range(0, 3)));
        end
        m1     = 2'($urandom_range(1, 3));
        m2     = 2'($urandom_range(1, 3));
        d1     = int'($urandom_range(0, TimeoutCyc));
        d2     = int'($urandom_range(0, TimeoutCyc));
        part   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        bad_at = (d1 > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, d1 - 1)) : -1;
        run_round(m1, d1, m2, d2, part, bad_at);
      end
    end

    // Asynchronous reset mid-COLLECT.
    do_start();
    run_round(2'b10, 0, 2'b10, 0, 2'b00, -1);
    p1_valid = 1'b1;
    p1_move  = 2'b01;
    tick();
    p1_valid = 1'b0;
    check_eq("pre_reset_ready", {p1_ready, p2_ready}, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    all_out = {p1_ready, p2_ready, core_primo, core_secondo, core_inizia, res_valid, res_manche,
               res_partita, round_cnt, busy, match_over, timeout_pulse, bad_move};
    check_eq("async_reset_outputs", all_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("post_reset_idle", {busy, match_over, round_cnt}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
